// File: rtl/onewire_master.sv
`default_nettype none
// ============================================================================
//  Module      : onewire_master
//  Description : 1-Wire bus initiator. Runs one transaction per accepted
//                start: reset pulse with presence detect, ROM command byte,
//                optional ROM phase (read 64 / write 64 bits), then a data
//                write phase of DATA_BITS bits. Open-drain: the block only
//                ever pulls the bus low and samples the wired-AND level.
//  Ports       : clk, reset         - clock, synchronous active-high reset
//                bus_in             - raw bus level (1 = released)
//                master_pull_low    - 1 = drive bus low
//                start              - transaction request (IDLE only)
//                cmd/rom_tx/data_tx - command, Match ROM ID, payload
//                busy/done          - activity flag, end-of-transaction pulse
//                no_presence        - no presence pulse seen (valid at done)
//                cmd_invalid        - unknown ROM command (valid at done)
//                rom_rx             - ROM ID captured under Read ROM
//  Revision    : 1.0 - initial release
// ============================================================================
module onewire_master #(
   parameter int CLKS_PER_US = 50,
   parameter int DATA_BITS   = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        bus_in,
   output logic        master_pull_low,
   input  logic        start,
   input  logic [7:0]  cmd,
   input  logic [63:0] rom_tx,
   input  logic [63:0] data_tx,
   output logic        busy,
   output logic        done,
   output logic        no_presence,
   output logic        cmd_invalid,
   output logic [63:0] rom_rx
);

   localparam int              c_ps_w         = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
   localparam logic [c_ps_w-1:0] c_ps_last    = c_ps_w'(CLKS_PER_US - 1);
   localparam logic [8:0]      c_us_rst_last  = 9'd479;
   localparam logic [8:0]      c_us_slot_last = 9'd69;
   localparam logic [8:0]      c_us_presence  = 9'd70;
   localparam logic [8:0]      c_us_rd_sample = 9'd15;
   localparam logic [8:0]      c_us_short     = 9'd6;
   localparam logic [8:0]      c_us_long      = 9'd60;
   localparam logic [6:0]      c_data_last    = 7'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RST_LOW  = 3'd1,
      S_RST_WAIT = 3'd2,
      S_CMD      = 3'd3,
      S_ROM_RD   = 3'd4,
      S_ROM_WR   = 3'd5,
      S_DATA_WR  = 3'd6,
      S_DONE     = 3'd7
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic                r_bus_meta;
   logic                r_bus_sync;
   logic [c_ps_w-1:0]   r_ps;
   logic [8:0]          r_us;
   logic [6:0]          r_bit;
   logic [7:0]          r_cmd;
   logic [63:0]         r_rom_tx;
   logic [63:0]         r_data_tx;
   logic                r_presence;
   logic                r_pull;
   logic                r_no_presence;
   logic                r_cmd_invalid;
   logic [63:0]         r_rom_rx;

   logic                w_tick;
   logic                w_on_us;
   logic                w_in_slot;
   logic                w_slot_end;
   logic                w_rst_end;
   logic                w_restart;
   logic                w_pull;
   logic                w_load;
   logic                w_set_np;
   logic                w_set_ci;
   logic                w_bit_step;
   logic                w_rx_we;

   // The prescaler wraps on w_tick; w_on_us marks the first clock of each
   // microsecond so that "sample at t" happens exactly once.
   assign w_tick     = (r_ps == c_ps_last);
   assign w_on_us    = (r_ps == '0);
   assign w_in_slot  = (r_state == S_CMD) || (r_state == S_ROM_RD) ||
                       (r_state == S_ROM_WR) || (r_state == S_DATA_WR);
   assign w_slot_end = w_in_slot && (r_us == c_us_slot_last) && w_tick;
   assign w_rst_end  = (r_us == c_us_rst_last) && w_tick;
   assign w_restart  = (w_state_next != r_state) || (r_state == S_IDLE) || w_slot_end;

   always_comb begin
      w_state_next = r_state;
      w_pull       = 1'b0;
      w_load       = 1'b0;
      w_set_np     = 1'b0;
      w_set_ci     = 1'b0;
      w_bit_step   = 1'b0;
      w_rx_we      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load       = 1'b1;
               w_state_next = S_RST_LOW;
            end
         end
         S_RST_LOW: begin
            w_pull = 1'b1;
            if (w_rst_end) w_state_next = S_RST_WAIT;
         end
         S_RST_WAIT: begin
            if (w_rst_end) begin
               if (r_presence) begin
                  w_state_next = S_CMD;
               end else begin
                  w_set_np     = 1'b1;
                  w_state_next = S_DONE;
               end
            end
         end
         S_CMD: begin
            w_pull = (r_us < (r_cmd[r_bit[2:0]] ? c_us_short : c_us_long));
            if (w_slot_end) begin
               if (r_bit == 7'd7) begin
                  case (r_cmd)
                     8'h33:   w_state_next = S_ROM_RD;
                     8'h55:   w_state_next = S_ROM_WR;
                     8'hCC:   w_state_next = S_DATA_WR;
                     default: begin
                        w_set_ci     = 1'b1;
                        w_state_next = S_DONE;
                     end
                  endcase
               end else begin
                  w_bit_step = 1'b1;
               end
            end
         end
         S_ROM_RD: begin
            w_pull  = (r_us < c_us_short);
            w_rx_we = (r_us == c_us_rd_sample) && w_on_us;
            if (w_slot_end) begin
               if (r_bit == 7'd63) w_state_next = S_DATA_WR;
               else                w_bit_step   = 1'b1;
            end
         end
         S_ROM_WR: begin
            w_pull = (r_us < (r_rom_tx[r_bit[5:0]] ? c_us_short : c_us_long));
            if (w_slot_end) begin
               if (r_bit == 7'd63) w_state_next = S_DATA_WR;
               else                w_bit_step   = 1'b1;
            end
         end
         S_DATA_WR: begin
            w_pull = (r_us < (r_data_tx[r_bit[5:0]] ? c_us_short : c_us_long));
            if (w_slot_end) begin
               if (r_bit == c_data_last) w_state_next = S_DONE;
               else                      w_bit_step   = 1'b1;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Bus synchronizer resets to the released level.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bus_meta <= 1'b1;
         r_bus_sync <= 1'b1;
      end else begin
         r_bus_meta <= bus_in;
         r_bus_sync <= r_bus_meta;
      end
   end

   // Time base: restarts on every state change and every slot boundary.
   // The bit counter clears on phase change only and advances per slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ps  <= '0;
         r_us  <= '0;
         r_bit <= '0;
      end else begin
         if (w_restart) begin
            r_ps <= '0;
            r_us <= '0;
         end else if (w_tick) begin
            r_ps <= '0;
            r_us <= r_us + 9'd1;
         end else begin
            r_ps <= r_ps + 1'b1;
         end
         if (w_state_next != r_state) r_bit <= '0;
         else if (w_bit_step)         r_bit <= r_bit + 7'd1;
      end
   end

   // The pull is registered so the pad sees a glitch-free drive; the
   // uniform one-cycle lag leaves every pulse width unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pull        <= 1'b0;
         r_cmd         <= '0;
         r_rom_tx      <= '0;
         r_data_tx     <= '0;
         r_presence    <= 1'b0;
         r_no_presence <= 1'b0;
         r_cmd_invalid <= 1'b0;
         r_rom_rx      <= '0;
      end else begin
         r_pull <= w_pull;
         if (w_load) begin
            r_cmd         <= cmd;
            r_rom_tx      <= rom_tx;
            r_data_tx     <= data_tx;
            r_presence    <= 1'b0;
            r_no_presence <= 1'b0;
            r_cmd_invalid <= 1'b0;
         end
         if ((r_state == S_RST_WAIT) && (r_us == c_us_presence) && w_on_us && !r_bus_sync)
            r_presence <= 1'b1;
         if (w_set_np) r_no_presence <= 1'b1;
         if (w_set_ci) r_cmd_invalid <= 1'b1;
         if (w_rx_we)  r_rom_rx[r_bit[5:0]] <= r_bus_sync;
      end
   end

   assign master_pull_low = r_pull;
   assign busy            = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done            = (r_state == S_DONE);
   assign no_presence     = r_no_presence;
   assign cmd_invalid     = r_cmd_invalid;
   assign rom_rx          = r_rom_rx;

endmodule
`default_nettype wire

// File: tb/tb_onewire_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_onewire_master
//  Description : Self-checking bench for onewire_master. A behavioural slave
//                answers presence and Read ROM; a monitor records every low
//                pulse of master_pull_low; a transaction-level model lists the
//                expected pulse widths, duration and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onewire_master;

   localparam int N   = 2;
   localparam int DB  = 8;
   localparam int PER = 10;
   localparam int US  = N * PER;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  cmd;
   logic [63:0] rom_tx;
   logic [63:0] data_tx;
   logic        master_pull_low;
   logic        busy;
   logic        done;
   logic        no_presence;
   logic        cmd_invalid;
   logic [63:0] rom_rx;
   logic        slave_pull;
   logic        bus_in;

   assign bus_in = !(master_pull_low || slave_pull);

   onewire_master #(.CLKS_PER_US(N), .DATA_BITS(DB)) dut (
      .clk             (clk),
      .reset           (reset),
      .bus_in          (bus_in),
      .master_pull_low (master_pull_low),
      .start           (start),
      .cmd             (cmd),
      .rom_tx          (rom_tx),
      .data_tx         (data_tx),
      .busy            (busy),
      .done            (done),
      .no_presence     (no_presence),
      .cmd_invalid     (cmd_invalid),
      .rom_rx          (rom_rx)
   );

   always #(PER/2) clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          n_done   = 0;
   bit          slave_present = 0;
   logic [63:0] slave_rom = '0;
   int          widths[$];
   int          exp_w[$];
   int          exp_cyc;
   logic        e_np;
   logic        e_ci;
   logic [63:0] exp_rom_rx = '0;

   always @(negedge clk) if (done === 1'b1) n_done++;

   // Pulse-width monitor, widths in clock cycles.
   initial begin : monitor
      time t0;
      forever begin
         @(posedge master_pull_low);
         t0 = $time;
         @(negedge master_pull_low);
         widths.push_back(int'(($time - t0) / PER));
      end
   end

   // Behavioural slave: presence 30..150 us after reset release, decodes the
   // command byte, and answers Read ROM by holding 0-bits low to 45 us.
   initial begin : slave
      time  t_fall;
      time  w;
      int   s_slot;
      logic [7:0] s_cmd;
      slave_pull = 1'b0;
      s_slot     = 100;
      s_cmd      = '0;
      forever begin
         @(posedge master_pull_low);
         t_fall = $time;
         if (slave_present && s_slot >= 8 && s_slot < 72 && s_cmd == 8'h33 &&
             !slave_rom[s_slot-8]) begin
            slave_pull = 1'b1;
            #(45*US);
            slave_pull = 1'b0;
            s_slot++;
         end else begin
            @(negedge master_pull_low);
            w = $time - t_fall;
            if (w >= 400*US) begin
               s_slot = 0;
               s_cmd  = '0;
               if (slave_present) begin
                  #(30*US);
                  slave_pull = 1'b1;
                  #(120*US);
                  slave_pull = 1'b0;
               end
            end else begin
               if (s_slot < 8) s_cmd[s_slot] = (w < 30*US);
               s_slot++;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transaction-level reference: list of low-pulse widths and total length.
   task automatic build_model(input logic [7:0] c, input logic [63:0] rom,
                              input logic [63:0] dat, input bit present);
      int us_total;
      exp_w.delete();
      exp_w.push_back(480*N);
      e_np     = !present;
      e_ci     = 1'b0;
      us_total = 960;
      if (present) begin
         for (int i = 0; i < 8; i++) exp_w.push_back((c[i] ? 6 : 60) * N);
         us_total += 8*70;
         if (c == 8'h33) begin
            for (int i = 0; i < 64; i++) exp_w.push_back(6 * N);
            us_total  += 64*70;
            exp_rom_rx = slave_rom;
         end else if (c == 8'h55) begin
            for (int i = 0; i < 64; i++) exp_w.push_back((rom[i] ? 6 : 60) * N);
            us_total += 64*70;
         end else if (c != 8'hCC) begin
            e_ci = 1'b1;
         end
         if (!e_ci) begin
            for (int i = 0; i < DB; i++) exp_w.push_back((dat[i] ? 6 : 60) * N);
            us_total += DB*70;
         end
      end
      exp_cyc = us_total * N;
   endtask

   task automatic run_txn(input string tag, input logic [7:0] c, input logic [63:0] rom,
                          input logic [63:0] dat, input bit present);
      int k;
      int bad;
      int d0;
      build_model(c, rom, dat, present);
      slave_present = present;
      @(negedge clk);
      cmd = c; rom_tx = rom; data_tx = dat; start = 1'b1;
      widths.delete();
      d0 = n_done;
      @(posedge clk);
      k = 0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) break;
         if (k == 0) begin
            start   = 1'b0;
            cmd     = 8'($urandom);
            rom_tx  = {$urandom, $urandom};
            data_tx = {$urandom, $urandom};
            check({tag, "_busy"}, 64'(busy), 64'd1);
            check({tag, "_status_clr"}, {62'd0, no_presence, cmd_invalid}, 64'd0);
         end
         if (k == 40) start = 1'b1;
         if (k == 41) start = 1'b0;
         k++;
         if (k > exp_cyc + 100) break;
      end
      check({tag, "_done"}, 64'(done), 64'd1);
      if (done !== 1'b1) begin
         reset = 1'b1;
         repeat (3) @(negedge clk);
         reset = 1'b0;
         return;
      end
      n_assert++;
      assert (k >= exp_cyc - 2 && k <= exp_cyc + 2) else begin
         n_fail++;
         $error("FAIL %s_cycles: observed %0d expected %0d", tag, k, exp_cyc);
      end
      check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      check({tag, "_no_presence"}, 64'(no_presence), 64'(e_np));
      check({tag, "_cmd_invalid"}, 64'(cmd_invalid), 64'(e_ci));
      check({tag, "_rom_rx"}, rom_rx, exp_rom_rx);
      check({tag, "_pulse_count"}, 64'(widths.size()), 64'(exp_w.size()));
      bad = -1;
      for (int i = 0; i < exp_w.size() && i < widths.size(); i++)
         if (bad < 0 && widths[i] != exp_w[i]) bad = i;
      if (bad >= 0)
         $display("  %s pulse %0d width %0d cycles, model %0d", tag, bad, widths[bad], exp_w[bad]);
      check({tag, "_first_bad_pulse"}, 64'(bad), 64'(-1));
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
      check({tag, "_done_count"}, 64'(n_done - d0), 64'd1);
      check({tag, "_status_hold"}, {62'd0, no_presence, cmd_invalid}, {62'd0, e_np, e_ci});
   endtask

   initial begin : main
      logic [7:0]  rc;
      int          k;
      int          d0;
      reset = 1'b1; start = 1'b0; cmd = '0; rom_tx = '0; data_tx = '0;
      repeat (5) @(negedge clk);
      check("rst_outputs", {58'd0, master_pull_low, busy, done, no_presence, cmd_invalid, 1'b0}, 64'd0);
      check("rst_rom_rx", rom_rx, 64'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_outputs", {59'd0, master_pull_low, busy, done, no_presence, cmd_invalid}, 64'd0);

      run_txn("t1_nopres", 8'hCC, 64'd0, 64'd0, 1'b0);
      run_txn("t2_skip", 8'hCC, 64'd0, 64'h0000_0000_0000_00A5, 1'b1);
      slave_rom = 64'h8F00_0012_3456_7828;
      run_txn("t3_read", 8'h33, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      run_txn("t4_match", 8'h55, 64'h8F00_0012_3456_7828, {$urandom, $urandom}, 1'b1);
      run_txn("t5_bad", 8'h42, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      run_txn("t5_skip", 8'hCC, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);

      for (int r = 0; r < 2; r++) begin
         case ($urandom_range(0, 3))
            0: rc = 8'hCC;
            1: rc = 8'h33;
            2: rc = 8'h55;
            default: begin
               rc = 8'($urandom);
               while (rc == 8'h33 || rc == 8'h55 || rc == 8'hCC) rc = 8'($urandom);
            end
         endcase
         slave_rom = {$urandom, $urandom};
         run_txn("rand", rc, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      end

      // Reset during the 20th ROM read slot.
      slave_present = 1'b1;
      slave_rom     = {$urandom, $urandom};
      @(negedge clk);
      cmd = 8'h33; start = 1'b1;
      widths.delete();
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (widths.size() < 1 + 8 + 19 && k < 20000) begin
         @(negedge clk);
         if (k == 40) start = 1'b1;
         if (k == 41) start = 1'b0;
         k++;
      end
      check("t6_reach_slot20", 64'(widths.size() >= 28), 64'd1);
      repeat (70*N) @(negedge clk);
      check("t6_busy_before", 64'(busy), 64'd1);
      d0 = n_done;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("t6_pull_after_reset", 64'(master_pull_low), 64'd0);
      check("t6_busy_after_reset", 64'(busy), 64'd0);
      check("t6_rom_rx_cleared", rom_rx, 64'd0);
      reset = 1'b0;
      repeat (300*N) @(negedge clk);
      check("t6_no_done", 64'(n_done - d0), 64'd0);
      check("t6_idle_pull", 64'(master_pull_low), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/onewire_master.md
Name: onewire_master

Overview:
- 1-Wire bus initiator. It is the counterpart of the slave controller in this codebase.
- One transaction consists of:
  - a reset pulse and presence detection;
  - one ROM command byte (Read ROM 0x33, Skip ROM 0xCC, Match ROM 0x55);
  - a ROM phase: read 64 bits for 0x33, write 64 bits for 0x55, nothing for 0xCC;
  - a data phase: write DATA_BITS bits.
- The bus is open-drain. The block drives only master_pull_low and samples the wired-AND bus through bus_in.

Parameters:
- CLKS_PER_US, 50, clk cycles per microsecond. One "us tick" is generated every CLKS_PER_US cycles.
- DATA_BITS, 64, number of data bits written in the data phase, 1..64.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- bus_in  in  1  raw bus level (1 = released/high)
- master_pull_low  out  1  1 = drive bus low
- start  in  1  transaction request; sampled only in IDLE
- cmd  in  8  ROM command; latched on accepted start
- rom_tx  in  64  ROM ID for Match ROM; latched on start; LSB sent first
- data_tx  in  64  data payload; latched on start; bit 0 sent first
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle pulse at transaction end
- no_presence  out  1  valid with done; 1 = no presence pulse seen
- cmd_invalid  out  1  valid with done; 1 = cmd not in {0x33,0xCC,0x55}
- rom_rx  out  64  ROM read under 0x33; first received bit goes to bit 0

Behaviour:
- Reset values: master_pull_low=0, busy=0, done=0, no_presence=0, cmd_invalid=0, rom_rx=0. State is IDLE, counters are 0, and the prescaler is cleared.
- Reset asserted mid-transaction takes effect on the next edge: master_pull_low=0 immediately, no done pulse.
- bus_in passes through a 2-flop synchronizer. All samples use the synchronized value.
- us counter and prescaler:
  - They restart at 0 on every state or slot entry.
  - All times below are in us from that entry.
  - Time t means the us counter equals t.
- IDLE:
  - Condition: start=1.
  - Action: latch cmd/rom_tx/data_tx and set busy.
  - Next: RST_LOW.
  - start while busy is ignored.
- RST_LOW:
  - master_pull_low=1 for 480 us.
  - Next: RST_WAIT.
- RST_WAIT:
  - Bus released.
  - Sample at t=70: sync bus=0 means presence.
  - At t=480:
    - presence seen: go to CMD;
    - no presence: set no_presence=1 and go to DONE.
- Write slot (total 70 us):
  - bit=1: pull low for t<6, release for the remainder.
  - bit=0: pull low for t<60, release for the remainder.
- Read slot (total 70 us):
  - Pull low for t<6, then release.
  - Sample the sync bus at t=15. Bit value = sampled level.
- CMD:
  - 8 write slots, cmd[0] first.
  - After bit 7, decode:
    - 0x33: go to ROM_RD.
    - 0x55: go to ROM_WR.
    - 0xCC: go to DATA_WR.
    - Other: set cmd_invalid=1 and go to DONE. No data phase.
- ROM_RD:
  - 64 read slots.
  - Bit k is stored in rom_rx[k]. rom_rx is updated only by this phase; it holds its value otherwise.
  - Next: DATA_WR.
- ROM_WR:
  - 64 write slots, rom_tx[0] first.
  - Next: DATA_WR.
- DATA_WR:
  - DATA_BITS write slots, data_tx[0] first.
  - Next: DONE.
- DONE:
  - One cycle: done=1, busy=0.
  - Next: IDLE.
- Status hold:
  - no_presence and cmd_invalid hold until the next accepted start, which clears them.
- Slot boundaries:
  - Slots are back-to-back. The next slot's low phase starts on the cycle after the previous slot's t=70.
  - A bit counter tracks slot position. It wraps nothing; it resets at each phase entry.
- Duration with CLKS_PER_US=N:
  - Phase times:
    - reset phase: 960N cycles;
    - each slot: 70N cycles.
  - Cycle counts measured from the start-accept edge to the done pulse have ±2 cycles tolerance.
  - Skip ROM: (960 + 70·(8+DATA_BITS))·N cycles.

Test Plan:
1. No slave model, start with cmd=0xCC. Expect: master_pull_low high for exactly 480N cycles; done pulses with no_presence=1 at about 960N; no further pulls.
2. Slave model pulls low from 30 to 150 us after release; cmd=0xCC; data_tx=64'h0000_0000_0000_00A5; DATA_BITS=8. Expect:
   - cmd low widths, LSB first: 60,60,6,6,60,60,6,6 us;
   - data widths: 6,60,6,60,60,6,60,6 us;
   - done with no_presence=0 and cmd_invalid=0.
3. cmd=0x33; slave model drives ROM 64'h8F00_0012_3456_7828 LSB first, holding low 6–45 us for 0-bits. Expect rom_rx=64'h8F00_0012_3456_7828 at done.
4. cmd=0x55; rom_tx=64'h8F00_0012_3456_7828. Expect 64 write slots whose widths decode exactly to rom_tx, followed by the data phase.
5. cmd=0x42 with presence. Expect 8 command slots, then done with cmd_invalid=1 and no data slots. Then start again with cmd=0xCC: cmd_invalid clears on start.
6. Assert reset during the 20th ROM_RD slot. Expect: master_pull_low=0 and busy=0 next cycle; no done pulse; rom_rx=0. A pulse on start while busy (before the reset) is ignored.
